// File: rtl/vmem_pkg.sv
// vmem_pkg: shared defaults and enums for the frame-buffer arbiter
package vmem_pkg;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 24;
   localparam int FIFO_DEPTH = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FILL} arb_state_t;
   typedef enum logic [1:0] {GNT_NONE, GNT_DISP, GNT_WR, GNT_FILL} grant_t;
endpackage

// File: rtl/vmem_arbiter_if.sv
// vmem_arbiter_if: single-port frame-buffer memory bus
interface vmem_arbiter_if #(
   parameter int ADDR_W = vmem_pkg::ADDR_W,
   parameter int DATA_W = vmem_pkg::DATA_W
);
   logic mem_en;
   logic mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
   modport slave (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/vmem_wr_fifo.sv
// vmem_wr_fifo: synchronous FIFO of {addr, data} pixel writes
module vmem_wr_fifo #(
   parameter int W = 43,
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  logic pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [$clog2(DEPTH):0] count,
   output logic full,
   output logic empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [W-1:0] store [DEPTH];
   logic [PW-1:0] rd, wr;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         rd <= '0;
         wr <= '0;
         count <= '0;
      end else begin
         if (push) wr <= wr + 1'b1;
         if (pop) rd <= rd + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   always_ff @(posedge clk)
      if (push) store[wr] <= din;
   assign dout = store[rd];
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: frame-buffer port arbiter; scan-out reads first, then queued writes, then fill
module vmem_arbiter import vmem_pkg::*; #(
   parameter int ADDR_W = vmem_pkg::ADDR_W,
   parameter int DATA_W = vmem_pkg::DATA_W,
   parameter int FIFO_DEPTH = vmem_pkg::FIFO_DEPTH
) (
   input  logic clk,
   input  logic resetn,
   input  logic disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic disp_valid,
   input  logic wr_valid,
   output logic wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic fill_start,
   input  logic [DATA_W-1:0] fill_color,
   output logic fill_busy,
   output logic fill_done,
   vmem_arbiter_if.master mem
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   arb_state_t state, next_state;
   grant_t grant;
   logic [ADDR_W-1:0] fill_ptr;
   logic [DATA_W-1:0] color;
   logic [ADDR_W+DATA_W-1:0] head;
   logic [CW-1:0] count, count_nxt;
   logic full, empty, push, pop;
   assign push = wr_valid & wr_ready & ~full;
   assign pop = grant == GNT_WR;
   assign count_nxt = count + CW'(push) - CW'(pop);
   vmem_wr_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .resetn(resetn), .push(push), .pop(pop), .din({wr_addr, wr_data}),
      .dout(head), .count(count), .full(full), .empty(empty)
   );
   // grant is forced idle while in reset so the port outputs drop asynchronously
   always_comb
      grant = !resetn ? GNT_NONE : disp_req ? GNT_DISP : !empty ? GNT_WR :
              state == ST_FILL ? GNT_FILL : GNT_NONE;
   always_comb
      next_state = state == ST_IDLE ? (fill_start ? ST_DRAIN : ST_IDLE) :
                   state == ST_DRAIN ? (count_nxt == '0 ? ST_FILL : ST_DRAIN) :
                   (grant == GNT_FILL && &fill_ptr) ? ST_IDLE : ST_FILL;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= ST_IDLE;
      else state <= next_state;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         fill_ptr <= '0;
         color <= '0;
         disp_valid <= 1'b0;
         fill_done <= 1'b0;
         wr_ready <= 1'b0;
      end else begin
         disp_valid <= disp_req;
         wr_ready <= next_state == ST_IDLE && count_nxt != CW'(FIFO_DEPTH);
         fill_done <= state == ST_FILL && next_state == ST_IDLE;
         if (state == ST_IDLE && fill_start) color <= fill_color;
         fill_ptr <= state == ST_DRAIN ? '0 : grant == GNT_FILL ? fill_ptr + 1'b1 : fill_ptr;
      end
   assign fill_busy = state != ST_IDLE;
   assign disp_data = mem.mem_rdata;
   assign mem.mem_en = grant != GNT_NONE;
   assign mem.mem_we = grant == GNT_WR || grant == GNT_FILL;
   assign mem.mem_addr = grant == GNT_DISP ? disp_addr : grant == GNT_WR ? head[ADDR_W+DATA_W-1:DATA_W] :
                         grant == GNT_FILL ? fill_ptr : '0;
   assign mem.mem_wdata = grant == GNT_WR ? head[DATA_W-1:0] : grant == GNT_FILL ? color : '0;
endmodule
